// File: rtl/fpnew_fma_share_ctrl_pkg.sv
// Shared types for the FMA sharing controller: FP formats, FMA opcodes, drain FSM states.
package fpnew_fma_share_ctrl_pkg;

  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  typedef enum logic [1:0] {
    FMADD  = 2'd0,
    FMSUB  = 2'd1,
    FNMSUB = 2'd2,
    FNMADD = 2'd3
  } fpnew_fma_op_e;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } share_state_e;

  function automatic int unsigned exp_bits(fp_format_e fmt);
    case (fmt)
      FP32:    return 8;
      FP64:    return 11;
      FP16:    return 5;
      FP8:     return 5;
      FP16ALT: return 8;
      default: return 11;
    endcase
  endfunction

  function automatic int unsigned man_bits(fp_format_e fmt);
    case (fmt)
      FP32:    return 23;
      FP64:    return 52;
      FP16:    return 10;
      FP8:     return 2;
      FP16ALT: return 7;
      default: return 52;
    endcase
  endfunction

  function automatic int unsigned fp_width(fp_format_e fmt);
    return 1 + exp_bits(fmt) + man_bits(fmt);
  endfunction

endpackage

// File: rtl/fpnew_share_rr_arb.sv
// Round-robin arbiter: first set request at or above ptr (with wrap) wins; one-hot grant plus index.
module fpnew_share_rr_arb #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx
);

  logic found;
  int   idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      idx = int'(ptr) + k;
      if (idx >= int'(NUM_REQ)) idx = idx - int'(NUM_REQ);
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/fpnew_fma_share_ctrl.sv
// Shares one fixed-latency FMA between NUM_REQ requesters with credit-protected result FIFO and drain FSM.
// Optional issue/stall statistics counters are enabled with `define FPNEW_SHARE_STATS_EN.
module fpnew_fma_share_ctrl
  import fpnew_fma_share_ctrl_pkg::*;
#(
  parameter  fp_format_e  FpFormat   = FP64,
  parameter  int unsigned NUM_REQ    = 4,
  parameter  int unsigned LATENCY    = 2,
  parameter  int unsigned FIFO_DEPTH = 4,
  localparam int unsigned WIDTH      = fp_width(FpFormat),
  localparam int unsigned ID_W       = $clog2(NUM_REQ)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  input  logic [NUM_REQ*2-1:0]         req_op_i,
  input  logic [NUM_REQ*3*WIDTH-1:0]   req_operands_i,
  output logic                         unit_valid_o,
  output logic [1:0]                   unit_op_o,
  output logic [3*WIDTH-1:0]           unit_operands_o,
  input  logic                         unit_valid_i,
  input  logic [WIDTH-1:0]             unit_result_i,
  output logic                         resp_valid_o,
  input  logic                         resp_ready_i,
  output logic [ID_W-1:0]              resp_id_o,
  output logic [WIDTH-1:0]             resp_result_o,
  input  logic                         flush_i,
  output logic                         flush_done_o,
`ifdef FPNEW_SHARE_STATS_EN
  output logic [31:0]                  stat_issued_o,
  output logic [31:0]                  stat_stall_o,
`endif
  output logic                         err_o
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned IFL_W  = $clog2(LATENCY + 1);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + LATENCY + 1);

  function automatic logic [PTR_W-1:0] ptr_inc(logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  share_state_e        state;
  logic [ID_W-1:0]     rr_ptr;
  logic                can_issue, grant_en, issue, drained;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_idx;

  logic [LATENCY-1:0]  vld_p;
  logic [ID_W-1:0]     id_p [LATENCY];
  logic [IFL_W-1:0]    in_flight;
  logic                tag_vld_last;
  logic [ID_W-1:0]     tag_id_last;

  logic [ID_W-1:0]     fifo_id  [FIFO_DEPTH];
  logic [WIDTH-1:0]    fifo_res [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [FCNT_W-1:0]   fifo_count;
  logic                fifo_empty, fifo_full;
  logic                push_req, push, pop, mismatch, overflow;

  // Issue stage: credits come from registered counts only, so a pop frees its slot one cycle later
  assign can_issue = (state == RUN) &&
                     ((CNT_W'(in_flight) + CNT_W'(fifo_count)) < CNT_W'(FIFO_DEPTH));
  assign grant_en  = rst_ni && can_issue && !flush_i;

  fpnew_share_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .req     (req_valid_i & {NUM_REQ{grant_en}}),
    .ptr     (rr_ptr),
    .gnt     (grant),
    .gnt_idx (grant_idx)
  );

  assign issue        = |grant;
  assign req_ready_o  = grant;
  assign unit_valid_o = issue;

  always_comb begin
    unit_op_o       = '0;
    unit_operands_o = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant[i]) begin
        unit_op_o       = req_op_i[2*i +: 2];
        unit_operands_o = req_operands_i[i*3*WIDTH +: 3*WIDTH];
      end
    end
  end

  // Writeback stage: last tag stage lines up with unit_valid_i
  assign tag_vld_last = vld_p[LATENCY-1];
  assign tag_id_last  = id_p[LATENCY-1];
  assign fifo_empty   = (fifo_count == '0);
  assign fifo_full    = (fifo_count == FCNT_W'(FIFO_DEPTH));
  assign push_req     = unit_valid_i && tag_vld_last;
  assign mismatch     = unit_valid_i ^ tag_vld_last;
  assign resp_valid_o = rst_ni && !fifo_empty;
  assign pop          = resp_valid_o && resp_ready_i;
  assign overflow     = push_req && fifo_full && !pop;
  assign push         = push_req && !overflow;
  assign drained      = (in_flight == '0) && fifo_empty;

  assign resp_id_o     = resp_valid_o ? fifo_id[rd_ptr]  : '0;
  assign resp_result_o = resp_valid_o ? fifo_res[rd_ptr] : '0;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr     <= '0;
      vld_p      <= '0;
      in_flight  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      err_o      <= 1'b0;
    end else begin
      if (issue) rr_ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      vld_p[0] <= issue;
      for (int k = 1; k < int'(LATENCY); k++) vld_p[k] <= vld_p[k-1];
      in_flight  <= in_flight + IFL_W'(issue) - IFL_W'(tag_vld_last);
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      fifo_count <= fifo_count + FCNT_W'(push) - FCNT_W'(pop);
      if (mismatch || overflow) err_o <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    id_p[0] <= grant_idx;
    for (int k = 1; k < int'(LATENCY); k++) id_p[k] <= id_p[k-1];
    if (push) begin
      fifo_id[wr_ptr]  <= tag_id_last;
      fifo_res[wr_ptr] <= unit_result_i;
    end
  end

  // DONE pulses once on entry; staying in DONE while flush_i is held blocks grants without re-pulsing
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state        <= RUN;
      flush_done_o <= 1'b0;
    end else begin
      flush_done_o <= 1'b0;
      case (state)
        RUN:     if (flush_i) state <= DRAIN;
        DRAIN:   if (drained) begin
                   state        <= DONE;
                   flush_done_o <= 1'b1;
                 end
        DONE:    if (!flush_i) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

`ifdef FPNEW_SHARE_STATS_EN
  function automatic logic [31:0] sat_inc(logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stat_issued_o <= '0;
      stat_stall_o  <= '0;
    end else begin
      if (issue) stat_issued_o <= sat_inc(stat_issued_o);
      if (|req_valid_i && (state == RUN) && !can_issue) stat_stall_o <= sat_inc(stat_stall_o);
    end
  end
`endif

endmodule

// File: tb/tb_fpnew_fma_share_ctrl.sv
// Randomized bench for fpnew_fma_share_ctrl against a transaction-level model of grants, credits and drain.
module tb_fpnew_fma_share_ctrl;
  import fpnew_fma_share_ctrl_pkg::*;

  localparam int N   = 4;
  localparam int LAT = 2;
  localparam int D   = 4;
  localparam int W   = 64;
  localparam int OPW = 3 * W;

  logic             clk = 1'b0;
  logic             rst_ni;
  logic [N-1:0]     req_valid_i;
  logic [N-1:0]     req_ready_o;
  logic [2*N-1:0]   req_op_i;
  logic [N*OPW-1:0] req_operands_i;
  logic             unit_valid_o;
  logic [1:0]       unit_op_o;
  logic [OPW-1:0]   unit_operands_o;
  logic             unit_valid_i;
  logic [W-1:0]     unit_result_i;
  logic             resp_valid_o;
  logic             resp_ready_i;
  logic [1:0]       resp_id_o;
  logic [W-1:0]     resp_result_o;
  logic             flush_i;
  logic             flush_done_o;
  logic             err_o;
`ifdef FPNEW_SHARE_STATS_EN
  logic [31:0]      stat_issued_o, stat_stall_o;
`endif

  fpnew_fma_share_ctrl dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_op_i       (req_op_i),
    .req_operands_i (req_operands_i),
    .unit_valid_o   (unit_valid_o),
    .unit_op_o      (unit_op_o),
    .unit_operands_o(unit_operands_o),
    .unit_valid_i   (unit_valid_i),
    .unit_result_i  (unit_result_i),
    .resp_valid_o   (resp_valid_o),
    .resp_ready_i   (resp_ready_i),
    .resp_id_o      (resp_id_o),
    .resp_result_o  (resp_result_o),
    .flush_i        (flush_i),
    .flush_done_o   (flush_done_o),
`ifdef FPNEW_SHARE_STATS_EN
    .stat_issued_o  (stat_issued_o),
    .stat_stall_o   (stat_stall_o),
`endif
    .err_o          (err_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: issued/popped/delivered totals, RR pointer, drain phase, expected response order
  int         m_ptr, m_iss, m_pop, m_dlv, m_phase;
  bit         m_err;
  bit         inj_unit;
  bit         hist_v [LAT];
  logic [W-1:0] hist_r [LAT];
  int         exp_id [$];
  logic [W-1:0] exp_res [$];

  task automatic chk(input string tag, input logic [OPW-1:0] obs, input logic [OPW-1:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_ptr = 0; m_iss = 0; m_pop = 0; m_dlv = 0; m_phase = 0; m_err = 0;
    exp_id.delete(); exp_res.delete();
    for (int k = 0; k < LAT; k++) begin hist_v[k] = 0; hist_r[k] = '0; end
  endtask

  task automatic set_req(input logic [N-1:0] v);
    req_valid_i = v;
    req_op_i    = 2*N'($urandom);
    for (int i = 0; i < N*OPW/32; i++) req_operands_i[32*i +: 32] = $urandom;
  endtask

  task automatic step();
    logic [N-1:0] eg;
    logic [W-1:0] r;
    int g, outst;
    bit blocked, evld;
    unit_valid_i  = hist_v[LAT-1] | inj_unit;
    unit_result_i = hist_v[LAT-1] ? hist_r[LAT-1] : {$urandom, $urandom};
    @(negedge clk);
    if (!rst_ni) begin
      chk("rst_ready", OPW'(req_ready_o), '0);
      chk("rst_unit_valid", OPW'(unit_valid_o), '0);
      chk("rst_resp_valid", OPW'(resp_valid_o), '0);
      model_reset();
    end else begin
      outst   = m_iss - m_pop;
      blocked = (m_phase != 0) || flush_i;
      eg = '0; g = -1;
      if (!blocked && outst < D)
        for (int k = 0; k < N; k++) begin
          int j;
          j = (m_ptr + k) % N;
          if (g < 0 && req_valid_i[j]) g = j;
        end
      if (g >= 0) eg[g] = 1'b1;
      chk("req_ready", OPW'(req_ready_o), OPW'(eg));
      chk("unit_valid", OPW'(unit_valid_o), OPW'(g >= 0));
      chk("unit_op", OPW'(unit_op_o), (g >= 0) ? OPW'(req_op_i[2*g +: 2]) : '0);
      chk("unit_operands", unit_operands_o, (g >= 0) ? req_operands_i[g*OPW +: OPW] : '0);
      evld = (m_dlv - m_pop) > 0;
      chk("resp_valid", OPW'(resp_valid_o), OPW'(evld));
      if (evld) begin
        chk("resp_id", OPW'(resp_id_o), OPW'(exp_id[0]));
        chk("resp_result", OPW'(resp_result_o), OPW'(exp_res[0]));
      end
      chk("flush_done", OPW'(flush_done_o), OPW'(m_phase == 2));
      chk("err", OPW'(err_o), OPW'(m_err));
      if (evld && resp_ready_i) begin
        void'(exp_id.pop_front()); void'(exp_res.pop_front()); m_pop++;
      end
      if (hist_v[LAT-1]) m_dlv++;
      if (inj_unit && !hist_v[LAT-1]) m_err = 1;
      for (int k = LAT-1; k > 0; k--) begin hist_v[k] = hist_v[k-1]; hist_r[k] = hist_r[k-1]; end
      hist_v[0] = (g >= 0);
      if (g >= 0) begin
        r = {$urandom, $urandom};
        hist_r[0] = r;
        exp_id.push_back(g); exp_res.push_back(r);
        m_iss++; m_ptr = (g + 1) % N;
      end
      case (m_phase)
        0: if (flush_i) m_phase = 1;
        1: if (outst == 0) m_phase = 2;
        default: m_phase = flush_i ? 3 : 0;
      endcase
    end
    @(posedge clk); #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int flush_cnt;

  initial begin
    rst_ni = 1'b0; resp_ready_i = 1'b0; flush_i = 1'b0; inj_unit = 0;
    unit_valid_i = 1'b0; unit_result_i = '0;
    set_req('0);
    model_reset();
    @(posedge clk); #1;
    steps(2);
    rst_ni = 1'b1;

    // back-to-back grants 0,1,2,3,0,... with free-flowing responses
    resp_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin set_req(4'b1111); step(); end
    set_req('0); steps(6);

    // credit exhaustion with a single requester, then release by pops
    resp_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) begin set_req(4'b0100); step(); end
    resp_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin set_req(4'b0100); step(); end
    set_req('0); steps(6);

    // flush with three ops outstanding
    resp_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin set_req(4'b0001); step(); end
    set_req(4'b1111); flush_i = 1'b1; step();
    flush_i = 1'b0; steps(3);
    resp_ready_i = 1'b1; steps(10);
    set_req('0); steps(4);

    // result without a tag
    inj_unit = 1; step();
    inj_unit = 0; steps(3);

    // reset with two results parked in the FIFO
    rst_ni = 1'b0; step(); rst_ni = 1'b1;
    resp_ready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin set_req(4'b0001); step(); end
    set_req('0); steps(4);
    rst_ni = 1'b0; step(); rst_ni = 1'b1;
    set_req(4'b1010); step();
    resp_ready_i = 1'b1; set_req('0); steps(5);

    // randomized traffic with back-pressure and occasional drains
    flush_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      set_req(N'($urandom));
      resp_ready_i = ($urandom_range(0, 9) < 7);
      if (flush_cnt > 0) flush_cnt--;
      else if ($urandom_range(0, 99) == 0) flush_cnt = $urandom_range(1, 6);
      flush_i = (flush_cnt > 0);
      step();
    end
    flush_i = 1'b0; resp_ready_i = 1'b1; set_req('0); steps(10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
